// File: rtl/echo_ctrl_if.sv
// Control/status bundle between the echo configuration sequencer and its surroundings.
// Requests and in_ready are single-cycle strobes sampled on the rising clock edge;
// there is no back-pressure, and the controller holds a request until it is serviced.
interface echo_ctrl_if #(
    parameter int ADDR_W = 15
);
    logic              req_delay;
    logic              req_att;
    logic              in_ready;
    logic              next_D;
    logic              next_H;
    logic [2:0]        delay_state;
    logic [1:0]        att_state;
    logic              ram_sel;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              echo_mute;
    logic              busy;
    logic [2:0]        dbg_state;

    modport slave (
        input  req_delay, req_att, in_ready,
        output next_D, next_H, delay_state, att_state,
               ram_sel, clr_we, clr_addr, echo_mute, busy, dbg_state
    );

    modport master (
        output req_delay, req_att, in_ready,
        input  next_D, next_H, delay_state, att_state,
               ram_sel, clr_we, clr_addr, echo_mute, busy, dbg_state
    );
endinterface

// File: rtl/echo_ctrl.sv
// Echo configuration sequencer: turns request pulses into sample-aligned next_D/next_H
// strobes, shadows delay/attenuation indices and zero-fills the delay RAM after delay changes.
module echo_ctrl #(
    parameter int ADDR_W   = 15,
    parameter bit FLUSH_EN = 1'b1,
    parameter int N_DELAY  = 5
) (
    input  logic        clk,
    input  logic        reset,
    echo_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT_S = 3'd1,
        S_APPLY  = 3'd2,
        S_FLUSH  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;
    localparam logic [2:0]        DELAY_LAST = 3'(N_DELAY - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_pend_d;
    logic              r_pend_h;
    logic              r_next_d;
    logic              r_next_h;
    logic [2:0]        r_delay;
    logic [1:0]        r_att;
    logic [ADDR_W-1:0] r_clr_addr;
    logic              w_enter_apply;
    logic              w_flush_go;

    assign w_enter_apply = (r_state == S_WAIT_S) && bus.in_ready;
    assign w_flush_go    = r_next_d && FLUSH_EN;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (r_pend_d || r_pend_h) w_next_state = S_WAIT_S;
            S_WAIT_S: if (bus.in_ready) w_next_state = S_APPLY;
            S_APPLY:  w_next_state = w_flush_go ? S_FLUSH : S_IDLE;
            S_FLUSH:  if (r_clr_addr == ADDR_LAST) w_next_state = S_DONE;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Strobes and shadow indices are captured on entry to APPLY so they change together;
    // a pending flag is only cleared if this APPLY actually serviced it, and a new pulse wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend_d   <= 1'b0;
            r_pend_h   <= 1'b0;
            r_next_d   <= 1'b0;
            r_next_h   <= 1'b0;
            r_delay    <= '0;
            r_att      <= '0;
            r_clr_addr <= '0;
        end else begin
            r_pend_d <= bus.req_delay | (r_pend_d & ~((r_state == S_APPLY) & r_next_d));
            r_pend_h <= bus.req_att   | (r_pend_h & ~((r_state == S_APPLY) & r_next_h));
            r_next_d <= w_enter_apply & r_pend_d;
            r_next_h <= w_enter_apply & r_pend_h;
            if (w_enter_apply && r_pend_d) begin
                r_delay <= (r_delay == DELAY_LAST) ? 3'd0 : r_delay + 3'd1;
            end
            if (w_enter_apply && r_pend_h) begin
                r_att <= r_att + 2'd1;
            end
            // The last address wraps back to 0, which is also the DONE value.
            if (r_state == S_FLUSH) begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end else begin
                r_clr_addr <= '0;
            end
        end
    end

    assign bus.next_D      = r_next_d;
    assign bus.next_H      = r_next_h;
    assign bus.delay_state = r_delay;
    assign bus.att_state   = r_att;
    assign bus.ram_sel     = (r_state == S_FLUSH);
    assign bus.clr_we      = (r_state == S_FLUSH);
    assign bus.clr_addr    = r_clr_addr;
    assign bus.echo_mute   = ((r_state == S_APPLY) && w_flush_go) ||
                             (r_state == S_FLUSH) || (r_state == S_DONE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_echo_ctrl.sv
// Directed bench for echo_ctrl: scoreboard of expected APPLY strobes plus a flush monitor
// that tracks write addresses, flush length and mute duration.
module tb_echo_ctrl;
    localparam int ADDR_W    = 10;
    localparam int FLUSH_LEN = 1 << ADDR_W;
    localparam int MUTE_LEN  = FLUSH_LEN + 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    echo_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    echo_ctrl #(.ADDR_W(ADDR_W), .FLUSH_EN(1'b1), .N_DELAY(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {next_D, next_H, delay_state, att_state}
    logic [6:0] exp_q[$];
    logic [6:0] mon_e;

    int n_assert  = 0;
    int n_fail    = 0;
    int n_apply   = 0;
    int n_flush   = 0;
    int flush_cnt = 0;
    int mute_cnt  = 0;
    int m_delay   = 0;
    int m_att     = 0;
    int m_apply   = 0;
    int exp_mute  = 0;
    bit prev_we   = 1'b0;
    bit done_seen = 1'b0;
    bit mon_en    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.next_D, bus.next_H, bus.delay_state, bus.att_state, bus.ram_sel,
                    bus.clr_we, bus.clr_addr, bus.echo_mute, bus.busy});
    endfunction

    task automatic push_apply(input bit d, input bit h);
        if (d) begin
            m_delay  = (m_delay + 1) % 5;
            exp_mute = exp_mute + MUTE_LEN;
        end
        if (h) m_att = (m_att + 1) % 4;
        exp_q.push_back({d, h, 3'(m_delay), 2'(m_att)});
        m_apply++;
    endtask

    task automatic pulse(input bit d, input bit h);
        @(posedge clk); #1;
        bus.req_delay = d;
        bus.req_att   = h;
        @(posedge clk); #1;
        bus.req_delay = 1'b0;
        bus.req_att   = 1'b0;
    endtask

    task automatic ready();
        @(posedge clk); #1;
        bus.in_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_ready = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        do begin
            @(posedge clk); #2;
            k++;
        end while (bus.busy && k < budget);
        check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (bus.echo_mute) mute_cnt++;
            if (done_seen) begin
                check("mute_fall", 32'({bus.echo_mute, bus.ram_sel, bus.clr_we, bus.busy}), 32'd0);
                done_seen = 1'b0;
            end
            if (bus.next_D || bus.next_H) begin
                n_apply++;
                if (exp_q.size() == 0) begin
                    check("unexpected_apply", 32'({bus.next_D, bus.next_H}), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("apply", 32'({bus.next_D, bus.next_H, bus.delay_state, bus.att_state}),
                          32'(mon_e));
                end
                check("apply_mute", 32'(bus.echo_mute), 32'(bus.next_D));
            end
            if (bus.clr_we) begin
                check("clr_addr", 32'(bus.clr_addr), 32'(flush_cnt));
                check("flush_ctl", 32'({bus.ram_sel, bus.echo_mute, bus.busy}), 32'b111);
                flush_cnt++;
            end else if (prev_we) begin
                check("flush_len", 32'(flush_cnt), 32'(FLUSH_LEN));
                check("done_out", 32'({bus.echo_mute, bus.ram_sel, bus.busy, bus.clr_addr}),
                      32'({1'b1, 1'b0, 1'b1, {ADDR_W{1'b0}}}));
                flush_cnt = 0;
                n_flush++;
                done_seen = 1'b1;
            end
        end
        prev_we = bus.clr_we;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus.req_delay = 1'b0;
        bus.req_att   = 1'b0;
        bus.in_ready  = 1'b0;

        // Reset, then 100 quiet cycles.
        repeat (3) @(posedge clk);
        #2;
        check("reset_outs", outs(), 32'd0);
        @(posedge clk); #1;
        reset  = 1'b1;
        mon_en = 1'b1;
        repeat (100) begin
            @(posedge clk); #2;
            check("idle_outs", outs(), 32'd0);
        end

        // Attenuation step, sample strobe 20 cycles later.
        pulse(1'b0, 1'b1);
        push_apply(1'b0, 1'b1);
        repeat (20) @(posedge clk);
        #2;
        check("att_wait", 32'({bus.busy, bus.next_D, bus.next_H}), 32'b100);
        ready();
        #1;
        check("att_strobe", 32'({bus.next_D, bus.next_H, bus.att_state, bus.echo_mute}),
              32'({1'b0, 1'b1, 2'd1, 1'b0}));
        wait_idle(20);
        check("att_mute", 32'(mute_cnt), 32'(exp_mute));

        // Delay step with full flush.
        pulse(1'b1, 1'b0);
        push_apply(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        ready();
        #1;
        check("delay_strobe",
              32'({bus.next_D, bus.next_H, bus.delay_state, bus.echo_mute, bus.ram_sel}),
              32'({1'b1, 1'b0, 3'd1, 1'b1, 1'b0}));
        wait_idle(FLUSH_LEN + 20);
        check("flush_count1", 32'(n_flush), 32'd1);
        check("delay_mute", 32'(mute_cnt), 32'(exp_mute));

        // Five more delay steps exercise the wrap.
        for (int i = 0; i < 5; i++) begin
            pulse(1'b1, 1'b0);
            push_apply(1'b1, 1'b0);
            ready();
            wait_idle(FLUSH_LEN + 20);
            check("wrap_state", 32'(bus.delay_state), 32'(m_delay));
        end
        check("flush_count6", 32'(n_flush), 32'd6);

        // Simultaneous requests give one APPLY with both strobes.
        pulse(1'b1, 1'b1);
        push_apply(1'b1, 1'b1);
        ready();
        #1;
        check("both_strobe", 32'({bus.next_D, bus.next_H}), 32'b11);
        wait_idle(FLUSH_LEN + 20);
        check("flush_count7", 32'(n_flush), 32'd7);

        // Requests during a flush are held and merged; in_ready during flush is ignored.
        pulse(1'b1, 1'b0);
        push_apply(1'b1, 1'b0);
        ready();
        repeat (2) @(posedge clk);
        #2;
        check("in_flush", 32'(bus.clr_we), 32'd1);
        repeat (3) pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        ready();
        k = 0;
        do begin
            @(posedge clk); #2;
            k++;
        end while (bus.clr_we && k < FLUSH_LEN + 10);
        check("flush_end_timeout", 32'(bus.clr_we), 32'd0);
        push_apply(1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #2;
        check("held_wait", 32'({bus.busy, bus.next_D, bus.next_H}), 32'b100);
        ready();
        #1;
        check("held_strobe", 32'({bus.next_D, bus.next_H, bus.att_state}),
              32'({1'b1, 1'b1, 2'(m_att)}));
        wait_idle(FLUSH_LEN + 20);
        check("flush_count9", 32'(n_flush), 32'd9);
        check("held_mute", 32'(mute_cnt), 32'(exp_mute));

        // Asynchronous reset in the middle of a flush.
        pulse(1'b1, 1'b0);
        push_apply(1'b1, 1'b0);
        ready();
        k = 0;
        do begin
            @(posedge clk); #2;
            k++;
        end while (bus.clr_addr != 10'd1000 && k < FLUSH_LEN + 10);
        check("mid_flush_addr", 32'(bus.clr_addr), 32'd1000);
        reset = 1'b0;
        #1;
        check("reset_abort", outs(), 32'd0);
        flush_cnt = 0;
        mute_cnt  = 0;
        exp_mute  = 0;
        m_delay   = 0;
        m_att     = 0;
        repeat (2) @(posedge clk);
        #1;
        done_seen = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #2;
        check("post_reset_outs", outs(), 32'd0);

        // Controller still works after the aborted flush.
        pulse(1'b0, 1'b1);
        push_apply(1'b0, 1'b1);
        ready();
        wait_idle(20);
        check("post_reset_att", 32'({bus.delay_state, bus.att_state}), 32'({3'd0, 2'd1}));
        repeat (3) @(posedge clk);
        #2;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("apply_count", 32'(n_apply), 32'(m_apply));
        check("final_mute", 32'(mute_cnt), 32'(exp_mute));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
